// File: rtl/uart_cmd_pkg.sv
// Shared types and defaults for the UART command assembler.
// Holds the assembler state encoding and parameter defaults.
package uart_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD
  } asm_state_t;

  localparam int BYTES_DEF   = 2;
  localparam int TIMEOUT_DEF = 1_000_000;

endpackage

// File: rtl/sat_timer.sv
// Saturating idle counter for the UART command assembler.
// Flags expiry once TIMEOUT_CYC-1 idle cycles have been counted.
module sat_timer
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYC);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && cnt != LIMIT) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == LIMIT);

endmodule

// File: rtl/uart_cmd_assembler.sv
// Packs consecutive UART bytes into one wide command word,
// with hold/ack handshake, overrun flag and inter-byte timeout.
module uart_cmd_assembler
  import uart_cmd_pkg::*;
#(
  parameter int BYTES       = BYTES_DEF,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_rdy,
  output logic               clr_rx_rdy,
  output logic [8*BYTES-1:0] cmd,
  output logic               cmd_rdy,
  input  logic               clr_cmd_rdy,
  output logic               overrun,
  output logic               timeout
);

  localparam int CW = $clog2(BYTES) + 1;
  localparam logic [CW-1:0] LAST = CW'(BYTES - 1);

  asm_state_t    state;
  asm_state_t    state_nxt;
  logic [CW-1:0] byte_cnt;
  logic [CW-1:0] cnt_nxt;
  logic [CW-1:0] idx;
  logic [CW-1:0] slot;
  logic          clr_q;
  logic          live;
  logic          accept;
  logic          discard;
  logic          expired;
  logic          tmr_clr;
  logic          tmr_en;

  always_comb begin
    // the byte just acknowledged is still visible for one cycle
    live      = rx_rdy & ~clr_q & ~rst;
    accept    = live & ((state != HOLD) | clr_cmd_rdy);
    discard   = live & (state == HOLD) & ~clr_cmd_rdy;
    state_nxt = state;
    cnt_nxt   = byte_cnt;
    timeout   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          cnt_nxt   = CW'(1);
          state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        if (accept) begin
          cnt_nxt = byte_cnt + 1'b1;
          if (byte_cnt == LAST) begin
            state_nxt = HOLD;
          end
        end else if (expired) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
          timeout   = 1'b1;
        end
      end
      HOLD: begin
        if (clr_cmd_rdy) begin
          if (accept) begin
            cnt_nxt   = CW'(1);
            state_nxt = COLLECT;
          end else begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
    if (rst) begin
      timeout = 1'b0;
    end
    idx        = (state == HOLD) ? '0 : byte_cnt;
    slot       = MSB_FIRST ? (LAST - idx) : idx;
    tmr_clr    = accept | (state_nxt != COLLECT);
    tmr_en     = (state == COLLECT) & ~rx_rdy;
    clr_rx_rdy = accept | discard;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt <= '0;
      cmd      <= '0;
      overrun  <= 1'b0;
      clr_q    <= 1'b0;
    end else begin
      byte_cnt <= cnt_nxt;
      clr_q    <= clr_rx_rdy;
      for (int i = 0; i < BYTES; i++) begin
        if (accept && slot == CW'(i)) begin
          cmd[8*i +: 8] <= rx_data;
        end
      end
      if (clr_cmd_rdy) begin
        overrun <= 1'b0;
      end else if (discard) begin
        overrun <= 1'b1;
      end
    end
  end

  assign cmd_rdy = (state == HOLD);

  sat_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expired(expired)
  );

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Directed bench for uart_cmd_assembler: two configurations,
// expected commands queued on send and checked on cmd_rdy.
module tb_uart_cmd_assembler;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  logic [7:0]  a_rx_data;
  logic        a_rx_rdy;
  logic        a_clr_rx_rdy;
  logic [15:0] a_cmd;
  logic        a_cmd_rdy;
  logic        a_clr_cmd_rdy;
  logic        a_overrun;
  logic        a_timeout;

  logic [7:0]  b_rx_data;
  logic        b_rx_rdy;
  logic        b_clr_rx_rdy;
  logic [31:0] b_cmd;
  logic        b_cmd_rdy;
  logic        b_clr_cmd_rdy;
  logic        b_overrun;
  logic        b_timeout;

  int vectors     = 0;
  int miscompares = 0;
  int a_pulses    = 0;
  int t_pulses    = 0;
  int t_first     = -1;

  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  uart_cmd_assembler #(
    .BYTES(2), .MSB_FIRST(1'b1), .TIMEOUT_CYC(16)
  ) dut_a (
    .clk(clk), .rst(rst),
    .rx_data(a_rx_data), .rx_rdy(a_rx_rdy),
    .clr_rx_rdy(a_clr_rx_rdy),
    .cmd(a_cmd), .cmd_rdy(a_cmd_rdy),
    .clr_cmd_rdy(a_clr_cmd_rdy),
    .overrun(a_overrun), .timeout(a_timeout)
  );

  uart_cmd_assembler #(
    .BYTES(4), .MSB_FIRST(1'b0), .TIMEOUT_CYC(16)
  ) dut_b (
    .clk(clk), .rst(rst),
    .rx_data(b_rx_data), .rx_rdy(b_rx_rdy),
    .clr_rx_rdy(b_clr_rx_rdy),
    .cmd(b_cmd), .cmd_rdy(b_cmd_rdy),
    .clr_cmd_rdy(b_clr_cmd_rdy),
    .overrun(b_overrun), .timeout(b_timeout)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic send_a(input logic [7:0] d);
    @(negedge clk);
    a_rx_data = d;
    a_rx_rdy  = 1'b1;
    #1;
    chk("a_clr_rx_rdy", 32'(a_clr_rx_rdy), 32'd1);
    if (a_clr_rx_rdy) a_pulses++;
    @(negedge clk);
    a_rx_rdy = 1'b0;
  endtask

  task automatic ack_a();
    @(negedge clk);
    a_clr_cmd_rdy = 1'b1;
    @(negedge clk);
    a_clr_cmd_rdy = 1'b0;
  endtask

  task automatic pop_a(input string tag);
    int n = 0;
    logic [31:0] e;
    while (a_cmd_rdy !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rdy"}, 32'(a_cmd_rdy), 32'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front()
                           : 32'hDEAD_0000;
    chk(tag, 32'(a_cmd), e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    a_rx_data     = 8'hFF;
    a_rx_rdy      = 1'b1;
    a_clr_cmd_rdy = 1'b0;
    b_rx_data     = 8'h00;
    b_rx_rdy      = 1'b0;
    b_clr_cmd_rdy = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_clr_rx", 32'(a_clr_rx_rdy), 32'd0);
    chk("rst_cmd", 32'(a_cmd), 32'd0);
    chk("rst_rdy", 32'(a_cmd_rdy), 32'd0);
    chk("rst_ovr", 32'(a_overrun), 32'd0);
    chk("rst_to", 32'(a_timeout), 32'd0);
    chk("rst_b_cmd", b_cmd, 32'd0);
    a_rx_rdy = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // four bytes, LSB-first
    exp_q.push_back(32'h4433_2211);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      b_rx_data = 8'(17 * (i + 1));
      b_rx_rdy  = 1'b1;
      #1;
      chk("b_clr_rx_rdy", 32'(b_clr_rx_rdy), 32'd1);
      @(negedge clk);
      b_rx_rdy = 1'b0;
    end
    chk("b_rdy", 32'(b_cmd_rdy), 32'd1);
    exp_v = exp_q.pop_front();
    chk("b_cmd_lsb", b_cmd, exp_v);

    // two bytes, MSB-first, latency and strobe count
    exp_q.push_back(32'h0000_A53C);
    a_pulses = 0;
    send_a(8'hA5);
    chk("a_rdy_early", 32'(a_cmd_rdy), 32'd0);
    send_a(8'h3C);
    chk("a_latency", 32'(a_cmd_rdy), 32'd1);
    chk("a_pulses", 32'(a_pulses), 32'd2);
    pop_a("a_cmd_msb");

    // byte while holding
    send_a(8'h77);
    chk("ovr_set", 32'(a_overrun), 32'd1);
    chk("ovr_cmd", 32'(a_cmd), 32'h0000_A53C);
    chk("ovr_rdy", 32'(a_cmd_rdy), 32'd1);
    ack_a();
    chk("ovr_clr", 32'(a_overrun), 32'd0);
    chk("ack_rdy", 32'(a_cmd_rdy), 32'd0);

    // partial command abandoned
    send_a(8'h12);
    for (int i = 0; i < 20; i++) begin
      #1;
      if (a_timeout) begin
        t_pulses++;
        if (t_first < 0) t_first = i;
      end
      @(negedge clk);
    end
    chk("to_pulses", 32'(t_pulses), 32'd1);
    chk("to_cycle", 32'(t_first), 32'd15);
    chk("to_rdy", 32'(a_cmd_rdy), 32'd0);
    exp_q.push_back(32'h0000_BEEF);
    send_a(8'hBE);
    send_a(8'hEF);
    pop_a("a_after_to");

    // ack and new byte in the same cycle
    @(negedge clk);
    a_clr_cmd_rdy = 1'b1;
    a_rx_data     = 8'h5A;
    a_rx_rdy      = 1'b1;
    #1;
    chk("merge_clr_rx", 32'(a_clr_rx_rdy), 32'd1);
    @(negedge clk);
    a_clr_cmd_rdy = 1'b0;
    a_rx_rdy      = 1'b0;
    chk("merge_ovr", 32'(a_overrun), 32'd0);
    chk("merge_rdy", 32'(a_cmd_rdy), 32'd0);
    exp_q.push_back(32'h0000_5AC3);
    send_a(8'hC3);
    pop_a("a_merge");

    // byte arriving on the expiry cycle wins
    ack_a();
    exp_q.push_back(32'h0000_0102);
    send_a(8'h01);
    repeat (14) @(negedge clk);
    @(negedge clk);
    a_rx_data = 8'h02;
    a_rx_rdy  = 1'b1;
    #1;
    chk("edge_clr_rx", 32'(a_clr_rx_rdy), 32'd1);
    chk("edge_to", 32'(a_timeout), 32'd0);
    @(negedge clk);
    a_rx_rdy = 1'b0;
    pop_a("a_edge");

    // reset mid-collect
    ack_a();
    send_a(8'h99);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_to", 32'(a_timeout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_cmd", 32'(a_cmd), 32'd0);
    chk("mid_rst_rdy", 32'(a_cmd_rdy), 32'd0);
    chk("mid_rst_ovr", 32'(a_overrun), 32'd0);
    exp_q.push_back(32'h0000_1357);
    send_a(8'h13);
    send_a(8'h57);
    pop_a("a_post_rst");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
